// File: rtl/regfile_snap_pkg.sv
// Shared types and constants for the regfile save/restore engine.
package regfile_snap_pkg;

  localparam int unsigned NUM_REGS       = 8;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned RD_LATENCY_DEF = 1;
  localparam int unsigned IDX_W          = $clog2(NUM_REGS);

  localparam logic [IDX_W-1:0] REG_AX = IDX_W'(0);
  localparam logic [IDX_W-1:0] REG_CX = IDX_W'(1);
  localparam logic [IDX_W-1:0] REG_DX = IDX_W'(2);
  localparam logic [IDX_W-1:0] REG_BX = IDX_W'(3);
  localparam logic [IDX_W-1:0] REG_SP = IDX_W'(4);
  localparam logic [IDX_W-1:0] REG_BP = IDX_W'(5);
  localparam logic [IDX_W-1:0] REG_SI = IDX_W'(6);
  localparam logic [IDX_W-1:0] REG_DI = IDX_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DUMP_OUT,
    ST_LOAD_IN,
    ST_WR,
    ST_VERIFY,
    ST_FIN
  } snap_state_t;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NUM_REGS - 1);
  endfunction

endpackage

// File: rtl/regfile_snapshot_if.sv
// Debug-bridge, stream and regfile-port bundle; master is the engine side.
interface regfile_snapshot_if;
  import regfile_snap_pkg::*;

  logic              core_halted;
  logic              start_dump;
  logic              start_load;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [IDX_W-1:0]  rf_rd_sel;
  logic [DATA_W-1:0] rf_rd_val;
  logic [IDX_W-1:0]  rf_wr_sel;
  logic [DATA_W-1:0] rf_wr_val;
  logic              rf_wr_en;
  logic              rf_is_8_bit;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [IDX_W-1:0]  dump_idx;
  logic              dump_last;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              verify_err;

  modport master (
    input  core_halted, start_dump, start_load, rf_rd_val, dump_ready, load_valid, load_data,
    output busy, done, aborted, rf_rd_sel, rf_wr_sel, rf_wr_val, rf_wr_en, rf_is_8_bit,
           dump_valid, dump_data, dump_idx, dump_last, load_ready, verify_err
  );

  modport slave (
    output core_halted, start_dump, start_load, rf_rd_val, dump_ready, load_valid, load_data,
    input  busy, done, aborted, rf_rd_sel, rf_wr_sel, rf_wr_val, rf_wr_en, rf_is_8_bit,
           dump_valid, dump_data, dump_idx, dump_last, load_ready, verify_err
  );
endinterface

// File: rtl/regfile_snap_rdwait.sv
// Read-latency down-counter; strobes on the last wait cycle and captures read data.
module regfile_snap_rdwait
  import regfile_snap_pkg::*;
#(
  parameter int unsigned LAT = RD_LATENCY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] rd_val_i,
  output logic              capture_c_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign capture_c_o = en_i && (cnt_q == '0);
  assign data_o      = data_q;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (start_i) begin
      cnt_d = CNT_W'(LAT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (capture_c_o) begin
      data_d = rd_val_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/regfile_snapshot.sv
// Debug dump/load engine for the 8x16 register file; owns the regfile ports while the core is halted.
// Optional readback check after a load: define REGFILE_SNAP_VERIFY_EN.
module regfile_snapshot
  import regfile_snap_pkg::*;
#(
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  regfile_snapshot_if.master bus
);

  snap_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              aborted_q, aborted_d;
  logic              capture;
  logic [DATA_W-1:0] rd_data;
  logic              halted;
  logic              load_hs;

  assign halted  = bus.core_halted;
  assign load_hs = (state_q == ST_LOAD_IN) && halted && bus.load_valid;

  regfile_snap_rdwait #(.LAT(RD_LATENCY)) u_rdwait (
    .clk_i      (clk),
    .rst_i      (reset),
    .start_i    (state_q == ST_RD_ISSUE),
    .en_i       (state_q == ST_RD_WAIT),
    .rd_val_i   (bus.rf_rd_val),
    .capture_c_o(capture),
    .data_o     (rd_data)
  );

`ifdef REGFILE_SNAP_VERIFY_EN
  logic              vmode_q, vmode_d;
  logic              verr_q, verr_d;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];

  // Shadow copy of every accepted load word, compared during the readback pass.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      shadow_q[idx_q] <= bus.load_data;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_d    = load_q;
    aborted_d = aborted_q;
`ifdef REGFILE_SNAP_VERIFY_EN
    vmode_d   = vmode_q;
    verr_d    = verr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (halted && (bus.start_dump || bus.start_load)) begin
          idx_d     = REG_AX;
          aborted_d = 1'b0;
`ifdef REGFILE_SNAP_VERIFY_EN
          vmode_d   = 1'b0;
          verr_d    = 1'b0;
`endif
          state_d   = bus.start_dump ? ST_RD_ISSUE : ST_LOAD_IN;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: begin
        // Losing the halt in any active state aborts the operation.
        if (!halted) begin
          state_d   = ST_FIN;
          aborted_d = 1'b1;
        end else begin
          case (state_q)
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
              if (capture) begin
`ifdef REGFILE_SNAP_VERIFY_EN
                state_d = vmode_q ? ST_VERIFY : ST_DUMP_OUT;
`else
                state_d = ST_DUMP_OUT;
`endif
              end
            end
            ST_DUMP_OUT: begin
              if (bus.dump_ready) begin
                if (is_last_idx(idx_q)) begin
                  state_d = ST_FIN;
                end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_RD_ISSUE;
                end
              end
            end
            ST_LOAD_IN: begin
              if (bus.load_valid) begin
                load_d  = bus.load_data;
                state_d = ST_WR;
              end
            end
            ST_WR: begin
              if (!is_last_idx(idx_q)) begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_LOAD_IN;
              end else begin
`ifdef REGFILE_SNAP_VERIFY_EN
                idx_d   = REG_AX;
                vmode_d = 1'b1;
                state_d = ST_RD_ISSUE;
`else
                state_d = ST_FIN;
`endif
              end
            end
`ifdef REGFILE_SNAP_VERIFY_EN
            ST_VERIFY: begin
              if (rd_data != shadow_q[idx_q]) begin
                verr_d = 1'b1;
              end
              if (is_last_idx(idx_q)) begin
                state_d = ST_FIN;
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_RD_ISSUE;
              end
            end
`endif
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      load_q    <= '0;
      aborted_q <= 1'b0;
`ifdef REGFILE_SNAP_VERIFY_EN
      vmode_q   <= 1'b0;
      verr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      load_q    <= load_d;
      aborted_q <= aborted_d;
`ifdef REGFILE_SNAP_VERIFY_EN
      vmode_q   <= vmode_d;
      verr_q    <= verr_d;
`endif
    end
  end

  // Write enable and stream handshakes are gated by the halt so an abort takes effect at once.
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_FIN);
  assign bus.aborted     = aborted_q;
  assign bus.rf_rd_sel   = idx_q;
  assign bus.rf_wr_sel   = idx_q;
  assign bus.rf_wr_val   = load_q;
  assign bus.rf_wr_en    = (state_q == ST_WR) && halted;
  assign bus.rf_is_8_bit = 1'b0;
  assign bus.dump_valid  = (state_q == ST_DUMP_OUT) && halted;
  assign bus.dump_data   = rd_data;
  assign bus.dump_idx    = idx_q;
  assign bus.dump_last   = (state_q == ST_DUMP_OUT) && is_last_idx(idx_q);
  assign bus.load_ready  = (state_q == ST_LOAD_IN) && halted;
`ifdef REGFILE_SNAP_VERIFY_EN
  assign bus.verify_err  = verr_q;
`else
  assign bus.verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_snapshot.sv
// Bench for regfile_snapshot: regfile model with read latency, scoreboard model, directed tests.
module tb_regfile_snapshot;
  import regfile_snap_pkg::*;

  localparam int unsigned LAT = 2;
`ifdef REGFILE_SNAP_VERIFY_EN
  localparam logic EXP_VERR = 1'b1;
`else
  localparam logic EXP_VERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_snapshot_if bus();
  regfile_snapshot #(.RD_LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Register file on the far side of the ports, RD_LATENCY-deep read pipe, optional bit flip on BP.
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] rd_pipe [LAT];
  logic              flip_en = 1'b0;
  logic              pre_we = 1'b0;
  logic [IDX_W-1:0]  pre_sel = '0;
  logic [DATA_W-1:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_we) rf[pre_sel] <= pre_val;
    else if (bus.rf_wr_en) rf[bus.rf_wr_sel] <= bus.rf_wr_val;
    rd_pipe[0] <= rf[bus.rf_rd_sel] ^ ((flip_en && bus.rf_rd_sel == REG_BP) ? 16'h0020 : 16'h0000);
    for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.rf_rd_val = rd_pipe[LAT-1];

  // Model: expected register contents, op-active tracking and stream scoreboards.
  logic [DATA_W-1:0] exp_rf [NUM_REGS];
  logic [DATA_W-1:0] dumped [NUM_REGS];
  logic [DATA_W-1:0] ld_q [$];
  logic              op_active = 1'b0, prev_done = 1'b0, hold_v = 1'b0;
  logic [DATA_W-1:0] hold_d;
  logic [IDX_W-1:0]  hold_i;
  logic              verr_at_done = 1'b0, abt_at_done = 1'b0;
  int beats = 0, last_cnt = 0, wr_pulses = 0, acc_cnt = 0, wr_cnt = 0, done_cnt = 0, exp_idx = 0;

  always @(negedge clk) begin
    logic was_active;
    logic [DATA_W-1:0] w;
    if (pre_we) exp_rf[pre_sel] = pre_val;
    if (reset) begin
      op_active = 1'b0; prev_done = 1'b0; hold_v = 1'b0;
    end else begin
      was_active = op_active;
      chk("busy", 32'(bus.busy), 32'(op_active));
      chk("is_8_bit", 32'(bus.rf_is_8_bit), 32'd0);
      if (hold_v && bus.core_halted) begin
        chk("hold_valid", 32'(bus.dump_valid), 32'd1);
        chk("hold_data", 32'(bus.dump_data), 32'(hold_d));
        chk("hold_idx", 32'(bus.dump_idx), 32'(hold_i));
      end
      hold_v = bus.dump_valid && !bus.dump_ready;
      hold_d = bus.dump_data;
      hold_i = bus.dump_idx;
      if (bus.dump_valid && bus.dump_ready) begin
        if (exp_idx < int'(NUM_REGS)) begin
          chk("dump_idx", 32'(bus.dump_idx), 32'(exp_idx));
          chk("dump_data", 32'(bus.dump_data), 32'(exp_rf[exp_idx]));
          chk("dump_last", 32'(bus.dump_last), 32'(exp_idx == int'(NUM_REGS) - 1));
          dumped[exp_idx] = bus.dump_data;
        end else chk("dump_extra_beat", 32'd1, 32'd0);
        if (bus.dump_last) last_cnt++;
        beats++;
        exp_idx++;
      end
      if (bus.load_valid && bus.load_ready) begin
        ld_q.push_back(bus.load_data);
        if (acc_cnt < int'(NUM_REGS)) exp_rf[acc_cnt] = bus.load_data;
        acc_cnt++;
      end
      if (bus.rf_wr_en) begin
        chk("wr_while_halted", 32'(bus.core_halted), 32'd1);
        if (ld_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          w = ld_q.pop_front();
          chk("wr_sel", 32'(bus.rf_wr_sel), 32'(wr_cnt));
          chk("wr_val", 32'(bus.rf_wr_val), 32'(w));
        end
        wr_cnt++;
        wr_pulses++;
      end
      if (bus.done) begin
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        done_cnt++;
        verr_at_done = bus.verify_err;
        abt_at_done  = bus.aborted;
        op_active    = 1'b0;
      end
      if (!was_active && bus.core_halted && (bus.start_dump || bus.start_load)) begin
        op_active = 1'b1;
        beats = 0; last_cnt = 0; wr_pulses = 0; acc_cnt = 0; wr_cnt = 0; done_cnt = 0; exp_idx = 0;
        ld_q.delete();
      end
      prev_done = bus.done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic sd, input logic sl);
    bus.start_dump = sd;
    bus.start_load = sl;
    tick();
    bus.start_dump = 1'b0;
    bus.start_load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin tick(); n++; end
    chk({nm, "_done_seen"}, 32'(bus.done), 32'd1);
    tick();
  endtask

  task automatic load_words(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      repeat (i % 3) tick();
      bus.load_valid = 1'b1;
      bus.load_data  = base + DATA_W'(i);
      while (!bus.load_ready && k < 50) begin tick(); k++; end
      if (k >= 50) chk("load_ready_timeout", 32'd1, 32'd0);
      tick();
      bus.load_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.core_halted = 1'b0; bus.start_dump = 1'b0; bus.start_load = 1'b0;
    bus.dump_ready = 1'b1; bus.load_valid = 1'b0; bus.load_data = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_aborted", 32'(bus.aborted), 32'd0);
    chk("rst_rd_sel", 32'(bus.rf_rd_sel), 32'd0);
    chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst_dump_data", 32'(bus.dump_data), 32'd0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_verify_err", 32'(bus.verify_err), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      pre_we = 1'b1; pre_sel = IDX_W'(i); pre_val = DATA_W'(16'h1111 * (i + 1));
      tick();
    end
    pre_we = 1'b0;
    bus.core_halted = 1'b1;
    tick();

    // 1: plain dump
    start_op(1'b1, 1'b0);
    wait_done("t1", 200);
    chk("t1_beats", 32'(beats), 32'd8);
    chk("t1_last_cnt", 32'(last_cnt), 32'd1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_beat3", 32'(dumped[3]), 32'h4444);
    chk("t1_beat7", 32'(dumped[7]), 32'h8888);
    chk("t1_aborted", 32'(bus.aborted), 32'd0);

    // 2: backpressure on beat 3
    start_op(1'b1, 1'b0);
    begin
      int k = 0;
      while (!(bus.dump_valid && bus.dump_idx == REG_BX) && k < 100) begin tick(); k++; end
      chk("t2_reach_beat3", 32'(bus.dump_valid), 32'd1);
    end
    bus.dump_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t2_stall_data", 32'(bus.dump_data), 32'h4444);
      chk("t2_stall_idx", 32'(bus.dump_idx), 32'd3);
    end
    bus.dump_ready = 1'b1;
    wait_done("t2", 200);
    chk("t2_beats", 32'(beats), 32'd8);

    // 3: load with gaps, then dump back
    start_op(1'b0, 1'b1);
    load_words(16'hA000, 8);
    wait_done("t3_load", 200);
    chk("t3_wr_pulses", 32'(wr_pulses), 32'd8);
    chk("t3_verify_err", 32'(bus.verify_err), 32'd0);
    start_op(1'b1, 1'b0);
    wait_done("t3_dump", 200);
    chk("t3_beats", 32'(beats), 32'd8);
    chk("t3_beat0", 32'(dumped[0]), 32'hA000);
    chk("t3_beat5", 32'(dumped[5]), 32'hA005);
    chk("t3_beat7", 32'(dumped[7]), 32'hA007);

    // 4: halt drops after three load beats
    start_op(1'b0, 1'b1);
    load_words(16'hB000, 3);
    tick();
    bus.core_halted = 1'b0;
    wait_done("t4", 50);
    chk("t4_abt_at_done", 32'(abt_at_done), 32'd1);
    chk("t4_aborted_sticky", 32'(bus.aborted), 32'd1);
    chk("t4_wr_pulses", 32'(wr_pulses), 32'd3);
    chk("t4_ax", 32'(rf[0]), 32'hB000);
    chk("t4_dx", 32'(rf[2]), 32'hB002);
    chk("t4_bx", 32'(rf[3]), 32'hA003);
    chk("t4_di", 32'(rf[7]), 32'hA007);
    for (int i = 0; i < int'(NUM_REGS); i++) chk("t4_rf_vs_model", 32'(rf[i]), 32'(exp_rf[i]));
    bus.core_halted = 1'b1;
    tick();

    // 5: simultaneous starts, then start while running core
    start_op(1'b1, 1'b1);
    wait_done("t5", 200);
    chk("t5_beats", 32'(beats), 32'd8);
    chk("t5_wr_pulses", 32'(wr_pulses), 32'd0);
    chk("t5_aborted_cleared", 32'(bus.aborted), 32'd0);
    chk("t5_beat2", 32'(dumped[2]), 32'hB002);
    bus.core_halted = 1'b0;
    start_op(1'b1, 1'b0);
    repeat (4) begin
      chk("t5_not_halted_busy", 32'(bus.busy), 32'd0);
      tick();
    end
    bus.core_halted = 1'b1;
    tick();

    // 6: load with a corrupted BP readback
    flip_en = 1'b1;
    start_op(1'b0, 1'b1);
    load_words(16'hC000, 8);
    wait_done("t6", 200);
    chk("t6_wr_pulses", 32'(wr_pulses), 32'd8);
    chk("t6_verify_err", 32'(verr_at_done), 32'(EXP_VERR));
    flip_en = 1'b0;

    // 7: reset in the middle of a dump
    start_op(1'b1, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("t7_busy", 32'(bus.busy), 32'd0);
    chk("t7_dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("t7_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t7_no_done", 32'(done_cnt), 32'd0);
    chk("t7_verify_err", 32'(bus.verify_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
